// File: rtl/fft_peak_picker.sv
// Peak picker between the FFT magnitude stream and the UART packet framer.
// Qualifying bins are queued as {eof, has_data, extra, idx, mag} and handed out one pulse at a time.
module fft_peak_picker #(
  parameter int DEPTH     = 16,
  parameter int MAX_PEAKS = 8,
  parameter int HOLDOFF   = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] cfg_threshold,
  input  logic [7:0]  cfg_extra,
  input  logic [15:0] s_bin_mag,
  input  logic        s_bin_valid,
  input  logic        s_bin_last,
  output logic [15:0] m_uart_addr,
  output logic [15:0] m_uart_data,
  output logic [7:0]  m_uart_extra,
  output logic        m_uart_valid,
  input  logic        m_uart_ready,
  output logic        m_uart_end,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAX_PEAKS + 1);
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int EOF_B  = 41;
  localparam int DATA_B = 40;

  localparam logic [CW-1:0] ROOM_DATA = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ROOM_ALL  = CW'(DEPTH);
  localparam logic [PW-1:0] PEAK_LIM  = PW'(MAX_PEAKS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_ENDCHK = 2'd3;

  logic [15:0]   bin_idx;
  logic          sof;
  logic [7:0]    frame_extra;
  logic [PW-1:0] frame_peaks;
  logic [7:0]    extra_now;
  logic          qualify;
  logic          push;
  logic          drop;
  logic          pop;
  logic [41:0]   push_entry_p0;

  logic [41:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [41:0]   rd_entry_p1;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;

  // Input stage: classify the beat and decide push/drop
  assign extra_now = sof ? cfg_extra : frame_extra;
  assign qualify   = s_bin_mag >= cfg_threshold;

  always_comb begin
    push          = 1'b0;
    drop          = 1'b0;
    push_entry_p0 = {1'b0, 1'b1, extra_now, bin_idx, s_bin_mag};
    if (s_bin_valid) begin
      if (!s_bin_last) begin
        if (qualify) begin
          if (count < ROOM_DATA && frame_peaks < PEAK_LIM) push = 1'b1;
          else                                            drop = 1'b1;
        end
      end else if (qualify && count < ROOM_ALL && frame_peaks < PEAK_LIM) begin
        push                 = 1'b1;
        push_entry_p0[EOF_B] = 1'b1;
      end else begin
        // The slot kept free by the data rule guarantees room for this end marker
        drop = qualify;
        if (frame_peaks != '0 && count < ROOM_ALL) begin
          push                  = 1'b1;
          push_entry_p0[EOF_B]  = 1'b1;
          push_entry_p0[DATA_B] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bin_idx     <= '0;
      sof         <= 1'b1;
      frame_peaks <= '0;
      drop_cnt    <= '0;
    end else begin
      if (s_bin_valid) begin
        bin_idx <= s_bin_last ? 16'd0 : bin_idx + 1'b1;
        sof     <= s_bin_last;
        if (s_bin_last)  frame_peaks <= '0;
        else if (push)   frame_peaks <= frame_peaks + 1'b1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (s_bin_valid && sof) frame_extra <= cfg_extra;
  end

  // FIFO storage: registered read, popped only from IDLE
  assign pop = (state == S_IDLE) && (count != '0);

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= push_entry_p0;
    if (pop)  rd_entry_p1 <= mem[rd_ptr];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Output stage: paced handoff to the framer
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      m_uart_valid <= 1'b0;
      m_uart_end   <= 1'b0;
      m_uart_addr  <= '0;
      m_uart_data  <= '0;
      m_uart_extra <= '0;
    end else begin
      m_uart_valid <= 1'b0;
      m_uart_end   <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      case (state)
        S_IDLE:  if (count != '0) state <= S_FETCH;
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          if (hold_cnt == '0 && m_uart_ready) begin
            if (rd_entry_p1[DATA_B]) begin
              m_uart_valid <= 1'b1;
              m_uart_addr  <= rd_entry_p1[31:16];
              m_uart_data  <= rd_entry_p1[15:0];
              m_uart_extra <= rd_entry_p1[39:32];
              hold_cnt     <= HOLD_LOAD;
            end
            state <= S_ENDCHK;
          end
        end
        default: begin
          if (!rd_entry_p1[EOF_B]) begin
            state <= S_IDLE;
          end else if (hold_cnt == '0 && m_uart_ready) begin
            m_uart_end <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_picker.sv
// Bench for fft_peak_picker: queue-based reference model of pushes, drops and the issued pulse order.
module tb_fft_peak_picker;

  localparam int DEPTH = 16;
  localparam int MAXP  = 8;
  localparam int HOLD  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_threshold;
  logic [7:0]  cfg_extra;
  logic [15:0] s_bin_mag;
  logic        s_bin_valid;
  logic        s_bin_last;
  logic [15:0] m_uart_addr;
  logic [15:0] m_uart_data;
  logic [7:0]  m_uart_extra;
  logic        m_uart_valid;
  logic        m_uart_ready;
  logic        m_uart_end;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  fft_peak_picker #(.DEPTH(DEPTH), .MAX_PEAKS(MAXP), .HOLDOFF(HOLD)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .cfg_threshold(cfg_threshold), .cfg_extra(cfg_extra),
    .s_bin_mag(s_bin_mag), .s_bin_valid(s_bin_valid), .s_bin_last(s_bin_last),
    .m_uart_addr(m_uart_addr), .m_uart_data(m_uart_data), .m_uart_extra(m_uart_extra),
    .m_uart_valid(m_uart_valid), .m_uart_ready(m_uart_ready), .m_uart_end(m_uart_end),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    bit          is_end;
    logic [15:0] a;
    logic [15:0] d;
    logic [7:0]  x;
    bit          retire;
  } ev_t;

  ev_t         evq[$];
  int          total = 0;
  int          bad = 0;
  int          m_idx, m_peaks, m_out, m_prev_out, m_drop;
  bit          m_sof;
  logic [7:0]  m_fx;
  logic [15:0] last_a, last_d;
  logic [7:0]  last_x;
  int          cyc = 0;
  int          last_pulse = -100;
  int          n_valid = 0;
  int          n_end = 0;
  logic [15:0] obs_a[$];
  logic [15:0] obs_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_ev(input bit is_end, input logic [15:0] a, input logic [15:0] d,
                        input logic [7:0] x, input bit retire);
    ev_t e;
    e.is_end = is_end; e.a = a; e.d = d; e.x = x; e.retire = retire;
    evq.push_back(e);
  endtask

  // Model: one entry stays staged in the presenter once anything is queued, so
  // FIFO occupancy is outstanding entries minus one when the previous cycle had any.
  always @(posedge clk) begin
    logic        r, v, l, q;
    logic [15:0] mg, th;
    logic [7:0]  cx, ex;
    int          occ;
    ev_t         e;
    r = rst; v = s_bin_valid; l = s_bin_last; mg = s_bin_mag; th = cfg_threshold; cx = cfg_extra;
    cyc++;
    if (r) begin
      m_idx = 0; m_sof = 1'b1; m_peaks = 0; m_out = 0; m_prev_out = 0; m_drop = 0;
      evq.delete();
      last_a = '0; last_d = '0; last_x = '0; last_pulse = -100;
    end else begin
      occ = m_out - ((m_prev_out > 0) ? 1 : 0);
      m_prev_out = m_out;
      if (v) begin
        ex = m_sof ? cx : m_fx;
        if (m_sof) m_fx = cx;
        q = (mg >= th);
        if (!l) begin
          if (q) begin
            if (occ < DEPTH - 1 && m_peaks < MAXP) begin
              add_ev(1'b0, 16'(m_idx), mg, ex, 1'b1);
              m_peaks++; m_out++;
            end else if (m_drop < 65535) m_drop++;
          end
        end else begin
          if (q && occ < DEPTH && m_peaks < MAXP) begin
            add_ev(1'b0, 16'(m_idx), mg, ex, 1'b0);
            add_ev(1'b1, '0, '0, '0, 1'b1);
            m_out++;
          end else begin
            if (q && m_drop < 65535) m_drop++;
            if (m_peaks > 0 && occ < DEPTH) begin
              add_ev(1'b1, '0, '0, '0, 1'b1);
              m_out++;
            end
          end
          m_peaks = 0;
        end
        m_idx = l ? 0 : m_idx + 1;
        m_sof = l;
      end
    end
    #1;
    if (r) begin
      chk("rst_valid", m_uart_valid, 0);
      chk("rst_end", m_uart_end, 0);
      chk("rst_addr", m_uart_addr, 0);
      chk("rst_data", m_uart_data, 0);
      chk("rst_extra", m_uart_extra, 0);
      chk("rst_drop", drop_cnt, 0);
    end else begin
      if (m_uart_valid || m_uart_end) begin
        chk("valid_end_excl", m_uart_valid & m_uart_end, 0);
        chk("pulse_spacing", (cyc - last_pulse) >= HOLD + 1, 1);
        last_pulse = cyc;
      end
      if (m_uart_valid) begin
        chk("valid_expected", (evq.size() > 0) && !evq[0].is_end, 1);
        if (evq.size() > 0 && !evq[0].is_end) begin
          e = evq.pop_front();
          last_a = e.a; last_d = e.d; last_x = e.x;
          if (e.retire) m_out--;
        end
        n_valid++;
        obs_a.push_back(m_uart_addr);
        obs_d.push_back(m_uart_data);
      end
      if (m_uart_end) begin
        chk("end_expected", (evq.size() > 0) && evq[0].is_end, 1);
        if (evq.size() > 0 && evq[0].is_end) begin
          e = evq.pop_front();
          if (e.retire) m_out--;
        end
        n_end++;
      end
      chk("addr", m_uart_addr, last_a);
      chk("data", m_uart_data, last_d);
      chk("extra", m_uart_extra, last_x);
      chk("drop_cnt", drop_cnt, m_drop);
    end
  end

  task automatic beat(input logic [15:0] m, input logic l);
    s_bin_valid = 1'b1; s_bin_mag = m; s_bin_last = l;
    @(negedge clk);
    s_bin_valid = 1'b0; s_bin_last = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    m_uart_ready = 1'b1;
    while (evq.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", evq.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_obs();
    n_valid = 0; n_end = 0;
    obs_a.delete(); obs_d.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f1[8];
    logic [15:0] d0;
    logic [15:0] m;
    int          len;
    rst = 1'b1; cfg_threshold = 16'd100; cfg_extra = 8'hA5;
    s_bin_mag = '0; s_bin_valid = 1'b0; s_bin_last = 1'b0; m_uart_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle input with ready high
    repeat (20) @(negedge clk);
    chk("idle_valids", n_valid, 0);
    chk("idle_ends", n_end, 0);
    chk("idle_drop", drop_cnt, 0);

    // Three peaks, last bin qualifies
    clear_obs();
    f1 = '{16'd5, 16'd200, 16'd7, 16'd150, 16'd0, 16'd0, 16'd0, 16'd300};
    for (int i = 0; i < 8; i++) beat(f1[i], i == 7);
    drain();
    chk("t2_nvalid", n_valid, 3);
    chk("t2_nend", n_end, 1);
    chk("t2_a0", obs_a[0], 1);  chk("t2_d0", obs_d[0], 200);
    chk("t2_a1", obs_a[1], 3);  chk("t2_d1", obs_d[1], 150);
    chk("t2_a2", obs_a[2], 7);  chk("t2_d2", obs_d[2], 300);
    chk("t2_extra", m_uart_extra, 8'hA5);

    // Last bin below threshold; flag byte changes after the first beat
    clear_obs();
    f1[7] = 16'd3;
    cfg_extra = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      beat(f1[i], i == 7);
      cfg_extra = 8'h77;
    end
    drain();
    chk("t3_nvalid", n_valid, 2);
    chk("t3_nend", n_end, 1);
    chk("t3_a1", obs_a[1], 3);
    chk("t3_extra", m_uart_extra, 8'h3C);

    clear_obs();
    for (int i = 0; i < 8; i++) beat(16'd0, i == 7);
    drain();
    chk("zero_nvalid", n_valid, 0);
    chk("zero_nend", n_end, 0);

    // Peak cap
    clear_obs();
    d0 = drop_cnt;
    for (int i = 0; i < 20; i++) beat(16'd500, i == 19);
    drain();
    chk("t4_nvalid", n_valid, 8);
    chk("t4_nend", n_end, 1);
    chk("t4_alast", obs_a[7], 7);
    chk("t4_drop", 32'(drop_cnt - d0), 12);

    // Two full frames while the framer is stalled
    clear_obs();
    d0 = drop_cnt;
    m_uart_ready = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) beat(16'd500, i == 15);
    repeat (10) @(negedge clk);
    chk("t5_stalled", n_valid, 0);
    chk("t5_drop", 32'(drop_cnt - d0), 16);
    drain();
    chk("t5_nvalid", n_valid, 16);
    chk("t5_nend", n_end, 2);

    // Reset while entries wait in the FIFO and the frame is still open
    clear_obs();
    m_uart_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(16'd200, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_uart_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_nvalid", n_valid, 0);
    chk("t6_nend", n_end, 0);
    beat(16'd0, 1'b0); beat(16'd250, 1'b0); beat(16'd0, 1'b0); beat(16'd0, 1'b1);
    drain();
    chk("t6_nvalid2", n_valid, 1);
    chk("t6_addr", obs_a[0], 1);

    // Randomized frames, ready and flag byte toggling
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 24);
      cfg_threshold = 16'($urandom_range(50, 400));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) m = 16'($urandom_range(0, 65535));
        else                           m = 16'($urandom_range(0, 500));
        cfg_extra = 8'($urandom_range(0, 255));
        m_uart_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 4) == 0) @(negedge clk);
        beat(m, i == len - 1);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
